// File: rtl/img_col_feeder.sv
// Column-word source for a 3-column image window buffer: scans a frame band by band from three
// row-bank memories and flags the cycles in which the downstream buffer holds a full 3x3 window.
module img_col_feeder #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_en,
    output logic [ADDR_W-1:0]    mem_addr0,
    output logic [ADDR_W-1:0]    mem_addr1,
    output logic [ADDR_W-1:0]    mem_addr2,
    input  logic [PIX_W-1:0]     mem_rdata0,
    input  logic [PIX_W-1:0]     mem_rdata1,
    input  logic [PIX_W-1:0]     mem_rdata2,
    output logic [3*PIX_W-1:0]   image_out,
    output logic                 out_valid,
    output logic                 window_valid,
    output logic [ADDR_W-1:0]    win_row,
    output logic [ADDR_W-1:0]    win_col
);

    localparam logic [ADDR_W-1:0] LastRow  = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] RowStep2 = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] MinCol   = ADDR_W'(2);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [1:0]          drain_q, drain_d;
    logic                en_q, en_d;
    logic [ADDR_W-1:0]   addr0_q, addr0_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;

    // Read-data stage tags travel alongside the memory latency.
    logic                rd_valid_q;
    logic [ADDR_W-1:0]   rd_row_q;
    logic [ADDR_W-1:0]   rd_col_q;

    logic                out_valid_q;
    logic [3*PIX_W-1:0]  image_q;
    logic [ADDR_W-1:0]   out_row_q;
    logic [ADDR_W-1:0]   out_col_q;

    logic                win_valid_q;
    logic [ADDR_W-1:0]   win_row_q;
    logic [ADDR_W-1:0]   win_col_q;

    logic                last_addr;
    logic                win_ok;

    assign last_addr = (row_q == LastRow) && (col_q == LastCol);
    // Columns 0 and 1 of a band still share the buffer with the previous band's tail.
    assign win_ok    = out_valid_q && (out_col_q >= MinCol);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        en_d    = 1'b0;
        addr0_d = '0;
        addr1_d = '0;
        addr2_d = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    row_d   = '0;
                    col_d   = '0;
                    en_d    = 1'b1;
                    addr1_d = RowStep;
                    addr2_d = RowStep2;
                end
            end
            StStream: begin
                if (last_addr) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    // Row-major layout: band wrap is just the next linear address.
                    en_d    = 1'b1;
                    addr0_d = addr0_q + 1'b1;
                    addr1_d = addr1_q + 1'b1;
                    addr2_d = addr2_q + 1'b1;
                    if (col_q == LastCol) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
            en_q    <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            en_q    <= en_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q  <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            out_valid_q <= 1'b0;
            image_q     <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            rd_valid_q  <= en_q;
            rd_row_q    <= row_q;
            rd_col_q    <= col_q;
            out_valid_q <= rd_valid_q;
            image_q     <= rd_valid_q ? {mem_rdata0, mem_rdata1, mem_rdata2} : '0;
            out_row_q   <= rd_row_q;
            out_col_q   <= rd_col_q;
            win_valid_q <= win_ok;
            win_row_q   <= win_ok ? out_row_q : '0;
            win_col_q   <= win_ok ? out_col_q - MinCol : '0;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDrain) && (drain_q == 2'd2);
    assign mem_en       = en_q;
    assign mem_addr0    = addr0_q;
    assign mem_addr1    = addr1_q;
    assign mem_addr2    = addr2_q;
    assign image_out    = image_q;
    assign out_valid    = out_valid_q;
    assign window_valid = win_valid_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;

endmodule
